// File: rtl/aes128_top.sv
// Iterative AES-128 encrypt/decrypt core. Free-running: a new run starts whenever
// {key, mode, input_message} differs from the operands captured for the last run.
module aes128_top (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic         mode,
  input  logic [127:0] input_message,
  output logic [127:0] output_message
);

  typedef enum logic [1:0] {IDLE, EXPAND, WHITEN, ROUND} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d, data_q, data_d;
  logic [127:0] st_q, st_d, out_q, out_d;
  logic         mode_q, mode_d, pend_q, pend_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] rk_q [11];
  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk_new;

  logic [127:0] rkr, subd, mix_in, mix_out, rnd_out;
  logic         last_rnd;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward and inverse S-box share one GF inverse; only the affine step moves.
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    logic [7:0] pre, y;
    pre = inv ? (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05) : x;
    y   = gf_inv(pre);
    return inv ? y : (y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63);
  endfunction

  function automatic logic [7:0] byte_at(input logic [127:0] s, input int unsigned n);
    return 8'(s >> (8 * (15 - n)));
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = inv ? r + 4 * ((c + 4 - r) % 4) : r + 4 * ((c + r) % 4);
        o   = {o[119:0], byte_at(s, src)};
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++) o = {o[119:0], sub_byte(byte_at(s, n), inv)};
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  cf;
    logic [7:0]   acc;
    o  = '0;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc = '0;
        for (int unsigned j = 0; j < 4; j++)
          acc = acc ^ gmul(8'(cf >> (8 * (3 - ((j + 4 - i) % 4)))), byte_at(s, 4 * c + j));
        o = {o[119:0], acc};
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w3, tmp, n0, n1, n2, n3;
    w3  = prev[31:0];
    tmp = {sub_byte(w3[23:16], 1'b0), sub_byte(w3[15:8], 1'b0),
           sub_byte(w3[7:0], 1'b0), sub_byte(w3[31:24], 1'b0)} ^ {rc, 24'h000000};
    n0  = prev[127:96] ^ tmp;
    n1  = prev[95:64] ^ n0;
    n2  = prev[63:32] ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    last_rnd = (rnd_q == 4'd10);
    rkr      = rk_q[mode_q ? 4'd10 - rnd_q : rnd_q];
    subd     = sub_bytes(shift_rows(st_q, mode_q), mode_q);
    // Decrypt adds the round key before InvMixColumns, encrypt after MixColumns.
    mix_in   = mode_q ? subd ^ rkr : subd;
    mix_out  = last_rnd ? mix_in : mix_cols(mix_in, mode_q);
    rnd_out  = mode_q ? mix_out : mix_out ^ rkr;

    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    data_d  = data_q;
    pend_d  = pend_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    out_d   = out_q;
    rk_we   = 1'b0;
    rk_idx  = rnd_q;
    rk_new  = key_step(rk_q[rnd_q - 4'd1], rcon(rnd_q));

    case (state_q)
      IDLE: begin
        if (pend_q || ({key, mode, input_message} != {key_q, mode_q, data_q})) begin
          key_d   = key;
          mode_d  = mode;
          data_d  = input_message;
          pend_d  = 1'b0;
          rnd_d   = 4'd1;
          rk_we   = 1'b1;
          rk_idx  = 4'd0;
          rk_new  = key;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_we = 1'b1;
        if (rnd_q == 4'd10) begin
          rnd_d   = 4'd1;
          state_d = WHITEN;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      WHITEN: begin
        st_d    = data_q ^ (mode_q ? rk_q[10] : rk_q[0]);
        state_d = ROUND;
      end
      ROUND: begin
        st_d = rnd_out;
        if (last_rnd) begin
          out_d   = rnd_out;
          rnd_d   = 4'd0;
          state_d = IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      pend_q  <= 1'b1;
      rnd_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_idx] <= rk_new;
  end

  assign output_message = out_q;

endmodule

// File: tb/tb_aes128_top.sv
// Directed and randomized bench for aes128_top against a table-driven AES-128 model
// (S-box and GF products derived from exp/log tables of generator 03).
module tb_aes128_top;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key;
  logic         mode;
  logic [127:0] input_message;
  logic [127:0] output_message;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_top dut (
    .clk            (clk),
    .reset          (reset),
    .key            (key),
    .mode           (mode),
    .input_message  (input_message),
    .output_message (output_message)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_t [256];
  logic [7:0] log_t [256];
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic gen_tables();
    logic [7:0] p, v;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = 8'(i);
      p = p ^ xt(p);
    end
    sbox_t[0] = 8'h63;
    for (int x = 1; x < 256; x++) begin
      v = exp_t[(255 - int'(log_t[x])) % 255];
      sbox_t[x] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] din,
                                           input logic dec);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = 8'(din >> (120 - 8 * n));
    if (!dec) begin
      for (int r = 0; r <= 10; r++) begin
        if (r > 0) begin
          for (int n = 0; n < 16; n++) t[n] = sbox_t[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
          if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
              a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
              t[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
              t[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
              t[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
              t[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
            end
          end
          s = t;
        end
        for (int n = 0; n < 16; n++) s[n] = s[n] ^ 8'(w[4 * r + n / 4] >> (24 - 8 * (n % 4)));
      end
    end else begin
      for (int r = 10; r >= 0; r--) begin
        if (r < 10) begin
          for (int n = 0; n < 16; n++)
            t[n] = isbox_t[s[(n % 4) + 4 * (((n / 4) + 4 - (n % 4)) % 4)]];
          s = t;
        end
        for (int n = 0; n < 16; n++) s[n] = s[n] ^ 8'(w[4 * r + n / 4] >> (24 - 8 * (n % 4)));
        if (r > 0 && r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(8'h0e, a0) ^ gm(8'h0b, a1) ^ gm(8'h0d, a2) ^ gm(8'h09, a3);
            s[4*c+1] = gm(8'h09, a0) ^ gm(8'h0e, a1) ^ gm(8'h0b, a2) ^ gm(8'h0d, a3);
            s[4*c+2] = gm(8'h0d, a0) ^ gm(8'h09, a1) ^ gm(8'h0e, a2) ^ gm(8'h0b, a3);
            s[4*c+3] = gm(8'h0b, a0) ^ gm(8'h0d, a1) ^ gm(8'h09, a2) ^ gm(8'h0e, a3);
          end
        end
      end
    end
    res = '0;
    for (int n = 0; n < 16; n++) res = {res[119:0], s[n]};
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // The next rising edge must be the capture edge (E0); samples follow E20 and E21.
  task automatic run_check(input string tag, input logic [127:0] exp_new,
                           input logic [127:0] exp_old, input int chg_at,
                           input logic [127:0] chg_val);
    for (int i = 0; i <= 21; i++) begin
      @(posedge clk);
      #1;
      if (i == chg_at) input_message = chg_val;
      if (i == 20) chk({tag, "_hold"}, output_message, exp_old);
    end
    chk(tag, output_message, exp_new);
  endtask

  logic [127:0] prev, expv, d1, d2;

  initial begin
    gen_tables();
    reset         = 1'b0;
    key           = B_KEY;
    mode          = 1'b0;
    input_message = B_PT;
    #1;
    chk("reset_out", output_message, '0);
    #21 reset = 1'b1;

    run_check("fipsB_enc", B_CT, '0, -1, '0);
    repeat (8) @(posedge clk);
    #1;
    chk("idle_hold", output_message, B_CT);

    mode = 1'b1; input_message = B_CT;
    run_check("alt_dec1", B_PT, B_CT, -1, '0);
    mode = 1'b0; input_message = B_PT;
    run_check("alt_enc2", B_CT, B_PT, -1, '0);
    mode = 1'b1; input_message = B_CT;
    run_check("alt_dec2", B_PT, B_CT, -1, '0);

    key = C_KEY; mode = 1'b0; input_message = C_PT;
    run_check("fipsC_enc", C_CT, B_PT, -1, '0);
    mode = 1'b1; input_message = C_CT;
    run_check("fipsC_dec", C_PT, C_CT, -1, '0);

    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    mode = 1'b0; input_message = d1;
    expv = ref_aes(C_KEY, d1, 1'b0);
    run_check("midrun_old", expv, C_PT, 5, d2);
    prev = expv;
    expv = ref_aes(C_KEY, d2, 1'b0);
    run_check("midrun_new", expv, prev, -1, '0);
    prev = expv;

    for (int k = 0; k < 6; k++) begin
      key           = {$urandom, $urandom, $urandom, $urandom};
      mode          = 1'($urandom_range(0, 1));
      input_message = {$urandom, $urandom, $urandom, $urandom};
      expv = ref_aes(key, input_message, mode);
      run_check($sformatf("rand%0d", k), expv, prev, -1, '0);
      prev = expv;
    end

    key = '0; mode = 1'b0; input_message = '0;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("reset_mid", output_message, '0);
    @(posedge clk);
    #1;
    chk("reset_held", output_message, '0);
    #3 reset = 1'b1;
    run_check("zero_rerun", Z_CT, '0, -1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
